// File: rtl/weight_stream_feeder_if.sv
// Parameter-memory read port between the weight stream feeder and the memory arbiter.
interface weight_stream_feeder_if #(
    parameter int BIT    = 32,
    parameter int ADDR_W = 16
);
    logic              mem_rd_en;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_grant;
    logic [BIT-1:0]    mem_rdata;

    modport master (output mem_rd_en, mem_addr, input mem_grant, mem_rdata);
    modport slave  (input mem_rd_en, mem_addr, output mem_grant, mem_rdata);
endinterface

// File: rtl/weight_stream_feeder.sv
// Streams one layer's kernel weights and then its biases from parameter memory,
// one word per granted read, in the order the weight array fills its registers.
module weight_stream_feeder #(
    parameter int BIT     = 32,
    parameter int CHANNEL = 1,
    parameter int BATCH   = 3,
    parameter int F_ROW   = 3,
    parameter int F_COL   = 3,
    parameter int ADDR_W  = 16,
    parameter int WBASE   = 0,
    parameter int BBASE   = 27
) (
    input  logic                   clk,
    input  logic                   rst_,
    input  logic                   start,
    weight_stream_feeder_if.master mem,
    output logic [BIT-1:0]         weight,
    output logic                   control_weight,
    output logic [BIT-1:0]         bias,
    output logic                   control_bias,
    output logic                   kernel_last,
    output logic                   busy,
    output logic                   done
);
    localparam int K      = F_ROW * F_COL;
    localparam int NW     = K * CHANNEL * BATCH;
    localparam int WCNT_W = $clog2(NW + 1);
    localparam int BCNT_W = $clog2(BATCH + 1);
    localparam int KCNT_W = $clog2(K + 1);

    localparam logic [WCNT_W-1:0] W_LAST = WCNT_W'(NW - 1);
    localparam logic [BCNT_W-1:0] B_LAST = BCNT_W'(BATCH - 1);
    localparam logic [KCNT_W-1:0] K_LAST = KCNT_W'(K - 1);

    typedef enum logic [2:0] {IDLE, W_RD, B_RD, DRAIN, FIN} state_e;

    state_e            state_q, state_d;
    logic [WCNT_W-1:0] wcnt_q, wcnt_d;
    logic [BCNT_W-1:0] bcnt_q, bcnt_d;
    logic [KCNT_W-1:0] kcnt_q, kcnt_d;
    logic              w_pend_q, w_pend_d;
    logic              b_pend_q, b_pend_d;
    logic              kl_q, kl_d;
    logic [BIT-1:0]    weight_q, weight_d;
    logic [BIT-1:0]    bias_q, bias_d;

    // NOTE: every variable gets a default before the case so no path leaves it unassigned (no latch).
    always_comb begin
        state_d  = state_q;
        wcnt_d   = wcnt_q;
        bcnt_d   = bcnt_q;
        kcnt_d   = kcnt_q;
        w_pend_d = 1'b0;
        b_pend_d = 1'b0;
        kl_d     = 1'b0;
        weight_d = w_pend_q ? mem.mem_rdata : weight_q;
        bias_d   = b_pend_q ? mem.mem_rdata : bias_q;

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = W_RD;
                    wcnt_d  = '0;
                    bcnt_d  = '0;
                    kcnt_d  = '0;
                end
            end
            W_RD: begin
                if (mem.mem_grant) begin
                    w_pend_d = 1'b1;
                    kl_d     = (kcnt_q == K_LAST);
                    kcnt_d   = (kcnt_q == K_LAST) ? '0 : kcnt_q + 1'b1;
                    if (wcnt_q == W_LAST) state_d = B_RD;
                    else                  wcnt_d  = wcnt_q + 1'b1;
                end
            end
            B_RD: begin
                if (mem.mem_grant) begin
                    b_pend_d = 1'b1;
                    if (bcnt_q == B_LAST) state_d = DRAIN;
                    else                  bcnt_d  = bcnt_q + 1'b1;
                end
            end
            DRAIN:   state_d = FIN;
            FIN:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk) begin
        if (rst_) begin
            state_q  <= IDLE;
            wcnt_q   <= '0;
            bcnt_q   <= '0;
            kcnt_q   <= '0;
            w_pend_q <= 1'b0;
            b_pend_q <= 1'b0;
            kl_q     <= 1'b0;
            weight_q <= '0;
            bias_q   <= '0;
        end else begin
            state_q  <= state_d;
            wcnt_q   <= wcnt_d;
            bcnt_q   <= bcnt_d;
            kcnt_q   <= kcnt_d;
            w_pend_q <= w_pend_d;
            b_pend_q <= b_pend_d;
            kl_q     <= kl_d;
            weight_q <= weight_d;
            bias_q   <= bias_d;
        end
    end

    // Weight addresses are linear because filter order (ch fastest) matches memory layout.
    always_comb begin
        mem.mem_rd_en = (state_q == W_RD) || (state_q == B_RD);
        mem.mem_addr  = '0;
        if (state_q == W_RD)      mem.mem_addr = ADDR_W'(WBASE) + ADDR_W'(wcnt_q);
        else if (state_q == B_RD) mem.mem_addr = ADDR_W'(BBASE) + ADDR_W'(bcnt_q);
    end

    // Read data arrives the cycle after issue, so it is forwarded live and captured to hold.
    assign weight         = w_pend_q ? mem.mem_rdata : weight_q;
    assign bias           = b_pend_q ? mem.mem_rdata : bias_q;
    assign control_weight = w_pend_q;
    assign control_bias   = b_pend_q;
    assign kernel_last    = kl_q;
    assign busy           = (state_q != IDLE);
    assign done           = (state_q == FIN);
endmodule

// File: tb/tb_weight_stream_feeder.sv
// Directed bench for weight_stream_feeder: default layer (plain, grant gaps, re-start,
// mid-stream reset) and a small 2x2x2x2 layer.
module tb_weight_stream_feeder;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_a, start_a, rst_b, start_b;
    logic [31:0] weight_a, bias_a, weight_b, bias_b;
    logic        cw_a, cb_a, kl_a, busy_a, done_a;
    logic        cw_b, cb_b, kl_b, busy_b, done_b;

    weight_stream_feeder_if #(.BIT(32), .ADDR_W(16)) ifa ();
    weight_stream_feeder_if #(.BIT(32), .ADDR_W(16)) ifb ();

    weight_stream_feeder dut_a (
        .clk(clk), .rst_(rst_a), .start(start_a), .mem(ifa),
        .weight(weight_a), .control_weight(cw_a), .bias(bias_a), .control_bias(cb_a),
        .kernel_last(kl_a), .busy(busy_a), .done(done_a)
    );

    weight_stream_feeder #(.CHANNEL(2), .BATCH(2), .F_ROW(2), .F_COL(2), .BBASE(16)) dut_b (
        .clk(clk), .rst_(rst_b), .start(start_b), .mem(ifb),
        .weight(weight_b), .control_weight(cw_b), .bias(bias_b), .control_bias(cb_b),
        .kernel_last(kl_b), .busy(busy_b), .done(done_b)
    );

    // Synchronous parameter memories with mem[a] = a + 1.
    always @(posedge clk) begin
        if (ifa.mem_rd_en && ifa.mem_grant) ifa.mem_rdata <= 32'(ifa.mem_addr) + 32'd1;
        if (ifb.mem_rd_en && ifb.mem_grant) ifb.mem_rdata <= 32'(ifb.mem_addr) + 32'd1;
    end

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Scenarios: 0 plain, 1 grant gaps, 2 start re-pulsed, 3 reset at 12 and restart at 15.
    function automatic int exp_cyc(input int sc, input int n, input bit second);
        case (sc)
            1:       return (n <= 4) ? n + 1 : (n <= 24) ? n + 4 : n + 6;
            3:       return second ? n + 16 : n + 1;
            default: return n + 1;
        endcase
    endfunction

    function automatic int exp_done(input int sc);
        case (sc)
            1:       return 37;
            3:       return 47;
            default: return 32;
        endcase
    endfunction

    function automatic bit exp_busy(input int sc, input int k);
        if (sc == 3) return (k >= 1 && k <= 12) || (k >= 16 && k <= 47);
        return (k >= 1 && k <= exp_done(sc));
    endfunction

    task automatic run_a(input int sc);
        int n = 0;
        int dones = 0;
        bit second = 1'b0;
        @(posedge clk); #1;
        start_a = 1'b1;
        ifa.mem_grant = 1'b1;
        for (int k = 1; k <= 55; k++) begin
            @(posedge clk); #1;
            start_a = (sc == 2 && (k == 5 || k == 32)) || (sc == 3 && k == 15);
            rst_a   = (sc == 3 && k == 12);
            ifa.mem_grant = !(sc == 1 && ((k >= 5 && k <= 7) || (k >= 28 && k <= 29)));
            @(negedge clk);
            check($sformatf("sc%0d c%0d excl", sc, k), {31'd0, cw_a & cb_a}, 0);
            check($sformatf("sc%0d c%0d busy", sc, k), {31'd0, busy_a}, {31'd0, exp_busy(sc, k)});
            if (sc == 3 && k == 13) begin
                check("sc3 words_before_reset", n, 11);
                n = 0;
                second = 1'b1;
            end
            if (sc == 3 && (k == 13 || k == 14)) begin
                check($sformatf("sc3 c%0d rst_weight", k), weight_a, 0);
                check($sformatf("sc3 c%0d rst_bias", k), bias_a, 0);
                check($sformatf("sc3 c%0d rst_flags", k),
                      {26'd0, cw_a, cb_a, kl_a, busy_a, done_a, ifa.mem_rd_en}, 0);
                check($sformatf("sc3 c%0d rst_addr", k), {16'd0, ifa.mem_addr}, 0);
            end
            if (cw_a || cb_a) begin
                n++;
                check($sformatf("sc%0d w%0d value", sc, n), cw_a ? weight_a : bias_a, n);
                check($sformatf("sc%0d w%0d is_weight", sc, n), {31'd0, cw_a}, {31'd0, n <= 27});
                check($sformatf("sc%0d w%0d cycle", sc, n), k, exp_cyc(sc, n, second));
                check($sformatf("sc%0d w%0d klast", sc, n), {31'd0, kl_a},
                      {31'd0, (n <= 27) && (n % 9 == 0)});
            end else begin
                check($sformatf("sc%0d c%0d klast_idle", sc, k), {31'd0, kl_a}, 0);
            end
            if (done_a) begin
                dones++;
                check($sformatf("sc%0d done_cycle", sc), k, exp_done(sc));
            end
            if (sc == 0 && k == 30) check("sc0 weight_hold", weight_a, 27);
            if (sc == 0 && k == 40) check("sc0 bias_hold", bias_a, 30);
        end
        check($sformatf("sc%0d word_count", sc), n, 30);
        check($sformatf("sc%0d done_count", sc), dones, 1);
    endtask

    task automatic run_b();
        int n = 0;
        int dones = 0;
        @(posedge clk); #1;
        start_b = 1'b1;
        ifb.mem_grant = 1'b1;
        for (int k = 1; k <= 30; k++) begin
            @(posedge clk); #1;
            start_b = 1'b0;
            @(negedge clk);
            check($sformatf("b c%0d excl", k), {31'd0, cw_b & cb_b}, 0);
            check($sformatf("b c%0d busy", k), {31'd0, busy_b}, {31'd0, k <= 20});
            check($sformatf("b c%0d rd_en", k), {31'd0, ifb.mem_rd_en}, {31'd0, k <= 18});
            if (k <= 18) check($sformatf("b c%0d addr", k), {16'd0, ifb.mem_addr}, k - 1);
            if (cw_b || cb_b) begin
                n++;
                check($sformatf("b w%0d value", n), cw_b ? weight_b : bias_b, n);
                check($sformatf("b w%0d is_weight", n), {31'd0, cw_b}, {31'd0, n <= 16});
                check($sformatf("b w%0d cycle", n), k, n + 1);
                check($sformatf("b w%0d klast", n), {31'd0, kl_b}, {31'd0, (n <= 16) && (n % 4 == 0)});
            end
            if (done_b) begin
                dones++;
                check("b done_cycle", k, 20);
            end
        end
        check("b word_count", n, 18);
        check("b done_count", dones, 1);
    endtask

    initial begin
        rst_a = 1'b1;
        rst_b = 1'b1;
        start_a = 1'b0;
        start_b = 1'b0;
        ifa.mem_grant = 1'b1;
        ifb.mem_grant = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset weight", weight_a, 0);
        check("reset bias", bias_a, 0);
        check("reset flags", {26'd0, cw_a, cb_a, kl_a, busy_a, done_a, ifa.mem_rd_en}, 0);
        check("reset addr", {16'd0, ifa.mem_addr}, 0);
        check("reset b flags", {26'd0, cw_b, cb_b, kl_b, busy_b, done_b, ifb.mem_rd_en}, 0);
        @(posedge clk); #1;
        rst_a = 1'b0;
        rst_b = 1'b0;

        run_a(0);
        run_a(1);
        run_a(2);
        run_a(3);
        run_b();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
